// File: rtl/sh_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sh_feed_ctrl
// Purpose  : Serializes a parallel word into a downstream shl/shr shift
//            register, one bit and one strobe per clock.
// Revision : 1.0 - initial release
// ============================================================================
module sh_feed_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_dir,
  input  logic                         flush,
  output logic                         d,
  output logic                         shl,
  output logic                         shr,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int              CW         = $clog2(WIDTH+1);
  localparam logic [CW-1:0]   c_LAST     = CW'(WIDTH-1);
  localparam logic [CW-1:0]   c_FULL     = CW'(WIDTH);
  localparam logic [3:0]      c_GAP_LOAD = 4'((GAP > 0) ? GAP-1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_buf;
  logic             r_dir;
  logic [3:0]       r_gap;
  logic             w_to_idle;

  assign in_ready = (r_state == S_IDLE);

  // Every non-idle state returns to IDLE on flush; DONE and GAP also on expiry.
  assign w_to_idle = (r_state != S_IDLE) &&
                     (flush ||
                      ((r_state == S_DONE) && (GAP == 0)) ||
                      ((r_state == S_GAP)  && (r_gap == 4'd0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_dir   <= 1'b0;
      r_gap   <= 4'd0;
      d       <= 1'b0;
      shl     <= 1'b0;
      shr     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
    end else if (w_to_idle) begin
      r_state <= S_IDLE;
      d       <= 1'b0;
      shl     <= 1'b0;
      shr     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_SHIFT;
            r_dir   <= in_dir;
            busy    <= 1'b1;
            bit_cnt <= '0;
            shl     <= ~in_dir;
            shr     <= in_dir;
            // First bit goes out immediately; the buffer keeps the rest.
            if (in_dir) begin
              d     <= in_data[0];
              r_buf <= in_data >> 1;
            end else begin
              d     <= in_data[WIDTH-1];
              r_buf <= in_data << 1;
            end
          end
        end
        S_SHIFT: begin
          if (bit_cnt == c_LAST) begin
            r_state <= S_DONE;
            d       <= 1'b0;
            shl     <= 1'b0;
            shr     <= 1'b0;
            done    <= 1'b1;
            bit_cnt <= c_FULL;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            if (r_dir) begin
              d     <= r_buf[0];
              r_buf <= r_buf >> 1;
            end else begin
              d     <= r_buf[WIDTH-1];
              r_buf <= r_buf << 1;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_GAP;
          r_gap   <= c_GAP_LOAD;
        end
        S_GAP: begin
          r_gap <= r_gap - 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sh_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sh_feed_ctrl
// Purpose  : Self-checking bench for sh_feed_ctrl, GAP=0 and GAP=3 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sh_feed_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          vld  [2];
  logic          dir  [2];
  logic          fl   [2];
  logic [W-1:0]  data [2];
  logic          rdy  [2];
  logic          dout [2];
  logic          shl  [2];
  logic          shr  [2];
  logic          busy [2];
  logic          done [2];
  logic [CW-1:0] bcnt [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    sh_feed_ctrl #(.WIDTH(W), .GAP((gi == 0) ? 0 : 3)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (vld[gi]),
      .in_ready (rdy[gi]),
      .in_data  (data[gi]),
      .in_dir   (dir[gi]),
      .flush    (fl[gi]),
      .d        (dout[gi]),
      .shl      (shl[gi]),
      .shr      (shr[gi]),
      .busy     (busy[gi]),
      .done     (done[gi]),
      .bit_cnt  (bcnt[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: word position k cycles after acceptance, plus the downstream register.
  bit           m_act    [2];
  int           m_k      [2];
  logic [W-1:0] m_word   [2];
  bit           m_dir    [2];
  logic [W-1:0] q        [2];
  int           strobes  [2];
  int           acc_last [2] = '{-1, -1};
  int           acc_diff [2] = '{-1, -1};
  int           edge_no = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]   = 1'b0;
        q[i]       = '0;
        strobes[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (shl[i])      q[i] = {q[i][W-2:0], dout[i]};
        else if (shr[i]) q[i] = {dout[i], q[i][W-1:1]};
        if (shl[i] || shr[i]) strobes[i]++;
        if (vld[i] && rdy[i]) begin
          if (acc_last[i] >= 0) acc_diff[i] = edge_no - acc_last[i];
          acc_last[i] = edge_no;
        end
        if (m_act[i]) begin
          if (fl[i]) m_act[i] = 1'b0;
          else begin
            m_k[i]++;
            if (m_k[i] > W + gap_of(i)) m_act[i] = 1'b0;
          end
        end else if (vld[i]) begin
          m_act[i]   = 1'b1;
          m_k[i]     = 0;
          m_word[i]  = data[i];
          m_dir[i]   = dir[i];
          strobes[i] = 0;
        end
      end
      edge_no++;
    end
  end

  always @(negedge clk) begin : p_check
    logic          e_str;
    logic          e_d;
    logic          e_done;
    logic [CW-1:0] e_bc;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        e_str = 1'b0; e_d = 1'b0; e_done = 1'b0; e_bc = '0;
        if (m_act[i]) begin
          if (m_k[i] < W) begin
            e_str = 1'b1;
            e_d   = m_dir[i] ? m_word[i][m_k[i]] : m_word[i][W-1-m_k[i]];
            e_bc  = CW'(m_k[i]);
          end else begin
            e_bc   = CW'(W);
            e_done = (m_k[i] == W);
          end
        end
        chk($sformatf("rdy%0d", i),  rdy[i],  !m_act[i]);
        chk($sformatf("busy%0d", i), busy[i], m_act[i]);
        chk($sformatf("shl%0d", i),  shl[i],  e_str & !m_dir[i]);
        chk($sformatf("shr%0d", i),  shr[i],  e_str & m_dir[i]);
        chk($sformatf("d%0d", i),    dout[i], e_d);
        chk($sformatf("done%0d", i), done[i], e_done);
        chk($sformatf("bcnt%0d", i), bcnt[i], e_bc);
        chk($sformatf("excl%0d", i), shl[i] & shr[i], 1'b0);
        if (e_done) begin
          chk($sformatf("q%0d", i),       q[i],       m_word[i]);
          chk($sformatf("strobes%0d", i), strobes[i], W);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input int i, input logic [W-1:0] w, input logic dv);
    int t = 0;
    vld[i] = 1'b1; data[i] = w; dir[i] = dv;
    while (!rdy[i] && t < 100) begin @(negedge clk); t++; end
    chk($sformatf("accept_to%0d", i), t < 100, 1'b1);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while (busy[i] && t < 100) begin @(negedge clk); t++; end
    chk($sformatf("idle_to%0d", i), t < 100, 1'b1);
  endtask

  task automatic back_to_back(input int i);
    int t = 0;
    vld[i] = 1'b1; data[i] = 8'h01; dir[i] = 1'b0;
    while (!rdy[i] && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    data[i] = 8'hFF;
    while (!rdy[i] && t < 200) begin @(negedge clk); t++; end
    chk($sformatf("b2b_to%0d", i), t < 200, 1'b1);
    @(negedge clk);
    vld[i] = 1'b0;
    chk($sformatf("b2b_gap%0d", i), acc_diff[i], W + 2 + gap_of(i));
    wait_idle(i);
  endtask

  task automatic flush_test(input int i);
    send(i, 8'hF0, 1'b0);
    repeat (2) @(negedge clk);
    fl[i] = 1'b1;
    @(negedge clk);
    fl[i] = 1'b0;
    chk($sformatf("fl_bcnt%0d", i), bcnt[i], 0);
    chk($sformatf("fl_rdy%0d", i),  rdy[i],  1'b1);
    chk($sformatf("fl_str%0d", i),  shl[i] | shr[i] | done[i], 1'b0);
    send(i, 8'h0F, 1'b0);
    wait_idle(i);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; dir[i] = 1'b0; fl[i] = 1'b0; data[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out%0d", i), {shl[i], shr[i], done[i], busy[i], dout[i]}, 5'd0);
      chk($sformatf("rst_bcnt%0d", i), bcnt[i], 0);
      chk($sformatf("rst_rdy%0d", i), rdy[i], 1'b1);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      send(i, 8'hA5, 1'b0); wait_idle(i);
      send(i, 8'h3C, 1'b1); wait_idle(i);
      back_to_back(i);
      flush_test(i);
    end

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        vld[i]  = 1'($urandom_range(0, 1));
        data[i] = W'($urandom);
        dir[i]  = 1'($urandom_range(0, 1));
        fl[i]   = ($urandom_range(0, 19) == 0);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin vld[i] = 1'b0; fl[i] = 1'b0; end
    for (int i = 0; i < 2; i++) wait_idle(i);

    // Asynchronous reset in the middle of a word.
    send(0, 8'hC3, 1'b0);
    send(1, 8'h81, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mid_rst%0d", i), {shl[i], shr[i], done[i], busy[i]}, 4'd0);
      chk($sformatf("mid_rst_bcnt%0d", i), bcnt[i], 0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("post_rst_rdy%0d", i), rdy[i], 1'b1);
    @(negedge clk);
    send(0, 8'h5A, 1'b1); wait_idle(0);
    send(1, 8'h96, 1'b0); wait_idle(1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sh_feed_ctrl.md
Name: sh_feed_ctrl

Overview:
- Serializing driver placed directly upstream of the 8-bit shl/shr shift register.
- Accepts a parallel word and a direction over a valid/ready handshake.
- Emits the word one bit per clock on d, with exactly WIDTH consecutive shl or shr strobes.
- After the last strobe, the downstream register's Q holds the word in either direction; done then pulses for one cycle.

Parameters:
WIDTH, 8, word width and strobe count; must match downstream register width; legal 2..32
GAP, 0, idle cycles after done before a new word is accepted; legal 0..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; shared with downstream register
in_valid  in  1  word offered
in_ready  out  1  block can accept word this cycle
in_data  in  WIDTH  word to load into downstream register
in_dir  in  1  0 = load via shl (MSB first), 1 = load via shr (LSB first)
flush  in  1  synchronous abort of word in progress
d  out  WIDTH=1  serial bit to downstream d (1 bit)
shl  out  1  shift-left strobe to downstream
shr  out  1  shift-right strobe to downstream
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, downstream Q == accepted word
bit_cnt  out  clog2(WIDTH+1)  strobes issued for current word

Behaviour:
- Reset (async, active-high) forces state IDLE, shl=0, shr=0, d=0, done=0, busy=0, bit_cnt=0, and clears the data/dir/gap registers. in_ready=1 once reset deasserts.
- Reset mid-word drops all strobes in the same instant; the word is lost with no done.
- All outputs except in_ready are registered. in_ready = (state==IDLE), combinational from state only.
- States: IDLE, SHIFT, DONE, GAP.
- IDLE:
  - Handshake when in_valid & in_ready at edge N: latch in_data into shift_buf and in_dir into dir_r; go to SHIFT.
  - in_valid without acceptance has no effect; in_data/in_dir are ignored outside acceptance.
- SHIFT: occupies clock cycles N+1 .. N+WIDTH (WIDTH cycles).
  - Exactly one of shl/shr is high every cycle: shl if dir_r=0, shr if dir_r=1. Never both.
  - dir_r=0: d presents in_data[WIDTH-1] first, down to bit 0 last.
  - dir_r=1: d presents bit 0 first, up to bit WIDTH-1 last.
  - bit_cnt increments on each strobe edge; it reads k during the cycle the (k+1)-th strobe is high.
  - Leave SHIFT after the WIDTH-th strobe.
- DONE: exactly one cycle (N+WIDTH+1), done=1, shl=shr=0, bit_cnt=WIDTH.
  - In this cycle downstream Q == accepted word. The downstream register has no reset gating on the data path beyond its own reset.
- GAP:
  - GAP=0: skip GAP; DONE -> IDLE.
  - GAP>0: hold GAP cycles with strobes low, then go to IDLE.
  - bit_cnt clears to 0 on entry to IDLE.
- Back-to-back: earliest next acceptance is cycle N+WIDTH+2+GAP. Steady-state throughput is one word per WIDTH+2+GAP cycles.
- flush=1 sampled in SHIFT, DONE or GAP: next cycle shl=shr=0, done=0, state IDLE, bit_cnt=0. No done for the aborted word.
  - Downstream Q holds a partial word; software must re-send.
- flush in IDLE: no effect. Acceptance in the same cycle as flush in IDLE is still honoured.
- d is 0 whenever both strobes are low.

Test Plan:
- Reset then IDLE: assert reset mid-run -> shl=shr=done=busy=0 immediately, in_ready=1 after deassert.
- Left load: accept in_data=8'hA5, in_dir=0 -> d sequence 1,0,1,0,0,1,0,1 with shl high 8 cycles, shr=0; done on 9th cycle after accept; downstream Q=8'hA5.
- Right load: accept 8'h3C, in_dir=1 -> d sequence 0,0,1,1,1,1,0,0 with shr high 8 cycles; done; Q=8'h3C.
- Back-to-back, GAP=0 vs GAP=3: in_valid held high with 8'h01 then 8'hFF -> second acceptance exactly 10 (GAP=0) or 13 (GAP=3) cycles after first; in_ready low throughout.
- Flush: accept 8'hF0 dir=0, flush after 3rd strobe -> strobes stop next cycle, no done, bit_cnt=0, in_ready=1; new word 8'h0F loads cleanly to Q=8'h0F.
- Protocol checks all runs: shl & shr never both 1; strobe count per completed word == WIDTH; done exactly once per completed word.
